// File: rtl/opl3_pkg.sv
// opl3_pkg: shared OPL3 types and host front-end defaults.
package opl3_pkg;

    typedef struct packed {
        logic       valid;
        logic       bank;
        logic [7:0] address;
        logic [7:0] data;
    } opl3_reg_wr_t;

    localparam int         HOST_FIFO_DEPTH     = 4;
    localparam int         HOST_MIN_WR_SPACING = 2;
    localparam int         HOST_FIFO_W         = 1 + 8 + 8;
    localparam logic [7:0] STATUS_RD_UNUSED    = 8'hFF;

endpackage

// File: rtl/opl3_host_fifo.sv
// opl3_host_fifo: generic synchronous FIFO, async reset; pushes when full and pops when empty are ignored.
module opl3_host_fifo #(
    parameter int W = 17,
    parameter int D = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(D):0]     count
);
    localparam int AW = $clog2(D);

    logic [W-1:0]  r_mem [D];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign empty  = r_cnt == '0;
    assign full   = r_cnt == (AW+1)'(D);
    assign count  = r_cnt;
    assign dout   = r_mem[r_rp];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= din;
    end

endmodule

// File: rtl/opl3_host_if.sv
// opl3_host_if: decodes OPL3 host ports, queues register writes and drains them
// as spaced reg_wr pulses; also returns the status byte on reads.
module opl3_host_if
    import opl3_pkg::*;
#(
    parameter int FIFO_DEPTH     = HOST_FIFO_DEPTH,
    parameter int MIN_WR_SPACING = HOST_MIN_WR_SPACING
) (
    input  logic         clk,
    input  logic         ic,
    input  logic         host_wr,
    input  logic         host_rd,
    input  logic [1:0]   host_addr,
    input  logic [7:0]   host_din,
    output logic [7:0]   host_dout,
    input  logic [7:0]   status_in,
    output logic         fifo_full,
    output logic         overflow,
    output opl3_reg_wr_t reg_wr
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = $clog2(MIN_WR_SPACING) + 1;

    logic [7:0]             r_addr;
    logic                   r_bank;
    logic [GW-1:0]          r_gap;
    logic                   r_ovf;
    logic [7:0]             r_dout;
    opl3_reg_wr_t           r_reg_wr;
    logic                   w_data_wr;
    logic                   w_pop;
    logic                   w_empty;
    logic                   w_full;
    logic [CW-1:0]          w_count;
    logic [HOST_FIFO_W-1:0] w_head;

    assign w_data_wr = host_wr & host_addr[0];
    assign w_pop     = ~w_empty & (r_gap == '0);
    assign fifo_full = w_count == CW'(FIFO_DEPTH);
    assign overflow  = r_ovf;
    assign host_dout = r_dout;
    assign reg_wr    = r_reg_wr;

    // Bank always comes from the last address write, never from the data port used.
    opl3_host_fifo #(.W(HOST_FIFO_W), .D(FIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (ic),
        .push (w_data_wr),
        .pop  (w_pop),
        .din  ({r_bank, r_addr, host_din}),
        .dout (w_head),
        .empty(w_empty),
        .full (w_full),
        .count(w_count)
    );

    always_ff @(posedge clk or posedge ic) begin
        if (ic) begin
            r_addr   <= '0;
            r_bank   <= 1'b0;
            r_gap    <= '0;
            r_ovf    <= 1'b0;
            r_dout   <= '0;
            r_reg_wr <= '0;
        end else begin
            if (host_wr && !host_addr[0]) begin
                r_addr <= host_din;
                r_bank <= host_addr[1];
            end
            if (w_data_wr && w_full) r_ovf <= 1'b1;
            r_gap <= w_pop ? GW'(MIN_WR_SPACING - 1) : (r_gap != '0 ? r_gap - 1'b1 : r_gap);
            r_reg_wr.valid <= w_pop;
            if (w_pop) {r_reg_wr.bank, r_reg_wr.address, r_reg_wr.data} <= w_head;
            if (host_rd) r_dout <= host_addr[0] ? STATUS_RD_UNUSED : status_in;
        end
    end

endmodule

// File: doc/opl3_host_if.md
# opl3_host_if

Host-side register write front end for the OPL3 core. It decodes the four OPL3 host ports: bank 0 address, data, bank 1 address, data. It pairs each data write with the latched address and bank, and buffers the result in a small FIFO. It drains the FIFO as single-cycle `opl3_reg_wr_t` pulses into the register file, with a guaranteed minimum spacing between pulses. It also returns the status byte on host reads. It sits between the SoC I/O decode (ports 0x388–0x38B) and the OPL3 register file.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: number of buffered register writes; must be a power of 2, at least 2.
- `MIN_WR_SPACING`, 2: minimum number of clk cycles between successive `reg_wr.valid` pulses; at least 1.

Ports:
- `clk`  in  1  core clock.
- `ic`  in  1  reset; asynchronous, active-high.
- `host_wr`  in  1  single-cycle write strobe.
- `host_rd`  in  1  single-cycle read strobe.
- `host_addr`  in  2  port select: 0 = bank 0 address, 1 = data, 2 = bank 1 address, 3 = data.
- `host_din`  in  8  write data.
- `host_dout`  out  8  registered read data.
- `status_in`  in  8  status byte from the timer block: {irq, ft1, ft2, 5'b0}.
- `fifo_full`  out  1  FIFO occupancy equals `FIFO_DEPTH`.
- `overflow`  out  1  sticky; set when a data write is dropped.
- `reg_wr`  out  `opl3_reg_wr_t`  register write to the register file; `valid` is a one-cycle pulse.

## Operation
- **Address write** (`host_wr`, `host_addr` = 0 or 2):
  - Latches `addr_q` ← `host_din`.
  - Latches `bank_q` ← `host_addr[1]`.
  - Nothing is pushed to the FIFO.
- **Data write** (`host_wr`, `host_addr` = 1 or 3):
  - Pushes {`bank_q`, `addr_q`, `host_din`}.
  - `host_addr[1]` is ignored; the bank always comes from the last address write.
  - `addr_q` and `bank_q` are retained, so repeated data writes reuse the same address.
- **Push when full:** if the FIFO is full, evaluated on the pre-edge count, the write is dropped and `overflow` is set. A pop in the same cycle does not rescue the write.
- **Strobes:** `host_wr` and `host_rd` asserted together: both actions are performed.
- **Drain control:**
  - Spacing counter `gap_q`.
  - A pop occurs when the FIFO is not empty and `gap_q` = 0.
  - On a pop, `gap_q` loads `MIN_WR_SPACING`−1. Otherwise `gap_q` decrements while nonzero.
- **Output register:**
  - On a pop, `reg_wr` ← {1, bank, address, data}.
  - On any other cycle, `reg_wr.valid` ← 0 and the other fields hold their previous values.
- **Read:**
  - `host_rd` with `host_addr[0]` = 0: `host_dout` ← `status_in`.
  - `host_rd` with `host_addr[0]` = 1: `host_dout` ← 8'hFF.
  - With no read strobe, `host_dout` holds.
- **FIFO pointers:** wrap modulo `FIFO_DEPTH`. The count is `$clog2(FIFO_DEPTH)+1` bits wide.
- **Simultaneous push and pop** when not full: the count is unchanged and both actions take effect.

## Timing
- **Reset values:** all outputs are 0. This covers `reg_wr` (all fields), `host_dout`, `fifo_full` and `overflow`. Internally, `addr_q`, `bank_q`, `gap_q`, the pointers and the count are also 0.
- **Reset mid-operation:** the FIFO is flushed and pending writes are lost. An in-flight `reg_wr.valid` drops immediately, because reset is asynchronous.
- **Latency, empty FIFO and `gap_q` = 0:** data write sampled at edge k → entry stored at edge k → `reg_wr.valid` high after edge k+1 for exactly one cycle.
- **Throughput:** one `reg_wr` per `MIN_WR_SPACING` cycles. With `MIN_WR_SPACING` = 1, pulses are back-to-back.
- **`fifo_full`** is registered from the count. It updates on the same edge as the push or pop that changes the count.
- **Read latency:** one cycle; `host_dout` is valid after the edge that sampled `host_rd`.
- **`overflow`** clears only on `ic`.

## Structure
- `opl3_reg_wr_t` is the existing shared struct in `opl3_pkg`; no new typedef is needed.
- Add to `opl3_pkg`:
  - `HOST_FIFO_DEPTH` = 4 and `HOST_MIN_WR_SPACING` = 2, used as defaults at instantiation.
  - `STATUS_RD_UNUSED` = 8'hFF.
- Sub-module `opl3_host_fifo`:
  - Generic synchronous FIFO with asynchronous reset, parameterized by width and depth.
  - Ports: `push`, `pop`, `din`, `dout`, `empty`, `full`, `count`.
  - Width = 1 + 8 + 8.
- Everything else lives in `opl3_host_if`:
  - address/bank latch
  - spacing counter
  - output register
  - read mux

## Test plan
- **Basic write:** write 0x20 to port 0, then 0x21 to port 1 → one `reg_wr` {valid=1, bank=0, address=0x20, data=0x21}, two cycles after the data strobe.
- **Bank 1 and address reuse:** port 2 ← 0x05, port 3 ← 0x01, port 1 ← 0x03 → two pulses: {1, 0x05, 0x01} then {1, 0x05, 0x03}. The second pulse uses bank 1 even though it was written through port 1.
- **Spacing:** `MIN_WR_SPACING` = 4; four data writes on consecutive cycles → four pulses exactly 4 cycles apart, data in write order.
- **Overflow:** `FIFO_DEPTH` = 4; six back-to-back data writes before any drain → `fifo_full` = 1. The fifth and sixth writes are dropped, `overflow` = 1, and only four pulses appear.
- **Read:** `status_in` = 8'hE0, read port 0 → `host_dout` = 8'hE0 next cycle. Read port 1 → 8'hFF.
- **Reset mid-stream:** assert `ic` with three entries queued and a pulse in flight → `reg_wr.valid` = 0 immediately. After release, no pulses appear; `overflow` = 0 and `fifo_full` = 0.
